// File: rtl/lc3_dmem.sv
// LC3-2 data memory: single-port 16-bit array, one-cycle registered read data.
// Optional post-reset zeroing sweep is compiled in with `LC3_DMEM_CLEAR_EN.
module lc3_dmem #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        DMem_en,
    input  logic        DMem_rd,
    input  logic [15:0] DMem_addr,
    input  logic [15:0] DMem_din,
    output logic [15:0] DMem_dout,
    output logic        DMem_ready
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [15:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr;
    logic                  req_rd;
    logic                  req_wr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [15:0]           wr_data;
    logic                  unused_addr_bits;

    // Upper address bits are deliberately dropped so addresses alias modulo DEPTH.
    assign addr             = DMem_addr[ADDR_WIDTH-1:0];
    assign unused_addr_bits = ^DMem_addr[15:ADDR_WIDTH];

    // A request coinciding with reset is dropped.
    assign req_rd = DMem_en &  DMem_rd & DMem_ready & ~reset;
    assign req_wr = DMem_en & ~DMem_rd & DMem_ready & ~reset;

`ifdef LC3_DMEM_CLEAR_EN
    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else if (state == S_CLEAR) begin
            // Counter parks at all-ones once the final word is cleared.
            if (cnt == '1) begin
                state <= S_READY;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign DMem_ready = (state == S_READY);

    // Sweep and request writes share one write port so the array maps to a RAM.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = addr;
        wr_data = DMem_din;
        if (!reset && state == S_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = cnt;
            wr_data = '0;
        end else if (req_wr) begin
            wr_en = 1'b1;
        end
    end
`else
    assign DMem_ready = 1'b1;

    always_comb begin
        wr_en   = req_wr;
        wr_addr = addr;
        wr_data = DMem_din;
    end
`endif

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            DMem_dout <= '0;
        end else if (req_rd) begin
            DMem_dout <= mem[addr];
        end
    end

endmodule

// File: tb/tb_lc3_dmem.sv
// Self-checking bench for lc3_dmem (ADDR_WIDTH = 4); follows `LC3_DMEM_CLEAR_EN
// so it matches whichever build of the memory it is compiled against.
module tb_lc3_dmem;

    logic        clk;
    logic        reset;
    logic        en;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        ready;

    int checks;
    int errors;

    lc3_dmem #(.ADDR_WIDTH(4)) dut (
        .clock     (clk),
        .reset     (reset),
        .DMem_en   (en),
        .DMem_rd   (rd),
        .DMem_addr (addr),
        .DMem_din  (din),
        .DMem_dout (dout),
        .DMem_ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a 16-word array with per-word "known" flags.
    logic [15:0] m_mem   [16];
    bit          m_known [16];
    logic [15:0] m_dout;
    bit          m_dk;
    bit          m_valid;
    bit          m_clear;
    int          m_cnt;

    initial begin
        m_valid = 0;
        m_clear = 0;
        m_dk    = 0;
        m_cnt   = 0;
        for (int i = 0; i < 16; i++) m_known[i] = 0;
    end

    always @(posedge clk) begin
        int a;
        a = int'(addr) % 16;
        if (reset) begin
            m_valid = 1;
            m_dout  = 16'h0000;
            m_dk    = 1;
`ifdef LC3_DMEM_CLEAR_EN
            m_clear = 1;
            m_cnt   = 0;
`endif
        end else if (m_clear) begin
            m_mem[m_cnt]   = 16'h0000;
            m_known[m_cnt] = 1;
            if (m_cnt == 15) m_clear = 0;
            else m_cnt++;
        end else if (en === 1'b1) begin
            if (rd) begin
                m_dout = m_mem[a];
                m_dk   = m_known[a];
            end else begin
                m_mem[a]   = din;
                m_known[a] = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_ready", {15'd0, ready}, {15'd0, !m_clear});
            if (m_dk) chk("model_dout", dout, m_dout);
        end
    end

    task automatic drive(input logic e, input logic r, input logic [15:0] a, input logic [15:0] d);
        en   = e;
        rd   = r;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'bz, 16'hzzzz, 16'hzzzz);
    endtask

    task automatic wait_ready(input string name, input int exp_cycles);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            idle();
            n++;
        end
        chk(name, 16'(n), 16'(exp_cycles));
    endtask

    initial begin
        int n;
        logic [15:0] held;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        en = 1'b0; rd = 1'b0; addr = 16'h0000; din = 16'h0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_dout", dout, 16'h0000);
`ifdef LC3_DMEM_CLEAR_EN
        chk("reset_ready", {15'd0, ready}, 16'h0000);
`else
        chk("reset_ready", {15'd0, ready}, 16'h0001);
`endif
        reset = 1'b0;

`ifdef LC3_DMEM_CLEAR_EN
        // Test 1: sweep length and zeroed array.
        wait_ready("sweep_cycles", 16);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 16'(i), 16'hFFFF);
            chk("clear_read", dout, 16'h0000);
        end
`else
        wait_ready("ready_cycles", 0);
`endif

        // Test 2: write then read, hold through idles and an unrelated write.
        drive(1'b1, 1'b0, 16'h0005, 16'h1234);
        drive(1'b1, 1'b1, 16'h0005, 16'h0000);
        chk("wr_rd", dout, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("hold_idle", dout, 16'h1234);
        end
        drive(1'b1, 1'b0, 16'h0006, 16'h5678);
        chk("hold_write", dout, 16'h1234);

        // Test 3: indirect read through the returned data.
        drive(1'b1, 1'b0, 16'h0002, 16'h0009);
        drive(1'b1, 1'b0, 16'h0009, 16'hBEEF);
        drive(1'b1, 1'b1, 16'h0002, 16'h0000);
        chk("ind_ptr", dout, 16'h0009);
        drive(1'b1, 1'b1, dout, 16'h0000);
        chk("ind_data", dout, 16'hBEEF);

        // Test 4: address aliasing modulo depth.
        drive(1'b1, 1'b0, 16'h0013, 16'hA5A5);
        drive(1'b1, 1'b1, 16'h0003, 16'h0000);
        chk("alias", dout, 16'hA5A5);
        drive(1'b1, 1'b1, 16'hFFF6, 16'h0000);
        chk("alias_hi", dout, 16'h5678);

`ifdef LC3_DMEM_CLEAR_EN
        // Test 5: reset mid-sweep (count 7) with a request in flight, then requests during sweep.
        reset = 1'b1;
        idle();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) idle();
        reset = 1'b1;
        drive(1'b1, 1'b0, 16'h0005, 16'hDEAD);
        reset = 1'b0;
        chk("rst_dout", dout, 16'h0000);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            if (n == 3)      drive(1'b1, 1'b0, 16'h000F, 16'hDEAD);
            else if (n == 5) drive(1'b1, 1'b1, 16'h0009, 16'h0000);
            else             idle();
            n++;
            if (n < 16) chk("sweep_dout", dout, 16'h0000);
        end
        chk("resweep_cycles", 16'(n), 16'd16);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 16'(i), 16'h0000);
            chk("resweep_read", dout, 16'h0000);
        end
        held = 16'h0000;
`else
        // Test 5: reset clears only the output register; in-flight write is dropped.
        reset = 1'b1;
        drive(1'b1, 1'b0, 16'h0005, 16'hDEAD);
        reset = 1'b0;
        chk("rst_dout", dout, 16'h0000);
        chk("rst_ready", {15'd0, ready}, 16'h0001);
        drive(1'b1, 1'b1, 16'h0005, 16'h0000);
        chk("rst_keep", dout, 16'h1234);
        held = 16'h1234;
`endif

        // Test 6: idle bus with floating controls changes nothing.
        drive(1'b1, 1'b1, 16'h0005, 16'h0000);
        chk("pre_idle", dout, held);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("z_idle", dout, held);
        end
        drive(1'b1, 1'b1, 16'h0005, 16'h0000);
        chk("post_idle", dout, held);

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
